mdu_e: RTL
==========

# mdu_e

Multiply/divide unit in the Execute stage, alongside the ALU, driven by the decoded E-stage instruction.
- Executes mult, multu, div, divu, mthi and mtlo against architectural HI/LO registers.
- Multiply and divide are multi-cycle: `busy` is held for a fixed latency, and HI/LO are committed only when the operation completes.
- Produces a combinational `stall` that the hazard logic uses to freeze F/D when a Decode-stage instruction needs the MDU while it is occupied.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu; legal range 1..31
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..31

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  E-stage instruction is an MDU op; sampled on clk
- op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6–7 reserved (no-op)
- a  in  32  rs operand (forwarded)
- b  in  32  rt operand (forwarded)
- md_use  in  1  D-stage instruction is an MDU op or mfhi/mflo
- busy  out  1  multi-cycle operation in progress
- stall  out  1  freeze F/D, bubble into E
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
States:
- IDLE: `busy` = 0.
- RUN: `busy` = 1; a 5-bit down-counter `cnt` tracks the remaining cycles.

IDLE, `start` = 1, op ∈ {0,1,2,3}:
- Result is computed from `a` and `b` at this edge and latched into pending registers `p_hi`/`p_lo`.
- `cnt` is loaded with MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3); state goes to RUN.

RUN:
- `cnt` decrements every cycle.
- On the edge where `cnt` == 1: `hi` ← `p_hi`, `lo` ← `p_lo`, state goes to IDLE.

IDLE, `start` = 1, op 4/5:
- `hi` ← `a` (op 4) or `lo` ← `a` (op 5) at that edge. No RUN state.

Start while in RUN (any op, including mthi/mtlo):
- Ignored; no state, counter or register changes.
- Upstream is required to prevent this through `stall`.

Reserved op values: no effect in either state.

Arithmetic:
- mult: signed 32×32→64; multu: unsigned. `hi` = product[63:32], `lo` = product[31:0].
- div: signed; quotient truncates toward zero; remainder takes the sign of the dividend. `lo` = quotient, `hi` = remainder.
- divu: unsigned.
- Divisor 0 (div or divu): full DIV_CYCLES busy, then `hi`/`lo` unchanged.
- div with 0x80000000 / 0xFFFFFFFF: `lo` = 0x80000000, `hi` = 0.

Stall:
- `stall` = `md_use` & (`busy` | (`start` & op ∈ {0,1,2,3})). Combinational.

Reset (async, any time, including mid-operation):
- `hi` = `lo` = 0; `p_hi` = `p_lo` = 0; `cnt` = 0; state IDLE.
- Outputs at reset: `busy` = 0, `stall` = 0 (given `md_use` = 0).
- Any pending result is discarded.

## Timing
- Start sampled at edge T: `busy` = 1 during cycles T+1 … T+N, where N = MULT_CYCLES or DIV_CYCLES.
- New `hi`/`lo` are visible, with `busy` = 0, from cycle T+N+1.
- mthi/mtlo: new value visible the cycle after the start edge.
- `stall` is asserted in the same cycle as the start (for the D-stage follower) and through the last busy cycle. It is deasserted in cycle T+N+1, so an mfhi/mflo in D reads the committed value with no bypass.
- Back-to-back: a new start is accepted in cycle T+N+1.
- `rst_n` assertion clears outputs without waiting for clk; deassertion takes effect at the next clk edge.

## Configuration
- Macro `MDU_DIV_EN`.
- Defined: div/divu are implemented as described above.
- Undefined:
  - No divider logic is synthesised.
  - op 2/3 are treated as reserved: no RUN state, `busy` stays 0, `hi`/`lo` unchanged.
  - `stall` ignores op 2/3.
- Multiply, mthi and mtlo are identical in both builds.

## Test plan
- mult, `a` = 0xFFFFFFFF, `b` = 2, start at T:
  - `busy` = 1 for T+1..T+5.
  - At T+6: `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFFE, `busy` = 0.
- multu, same operands: `hi` = 0x00000001, `lo` = 0xFFFFFFFE after 5 busy cycles.
- div, `a` = 0xFFFFFFF9 (−7), `b` = 2:
  - 10 busy cycles.
  - `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
  - Without `MDU_DIV_EN`: `busy` never asserts and `hi`/`lo` hold their previous values.
- divu with `b` = 0, prior `hi`/`lo` = 0x11111111/0x22222222: 10 busy cycles, then `hi`/`lo` still 0x11111111/0x22222222.
- During a multu run:
  - mthi with `a` = 0xDEADBEEF is ignored; `hi` ends as the product.
  - With `md_use` = 1, `stall` = 1 from the start cycle through T+5 and 0 at T+6.
- Reset mid-operation: mult started at T, `rst_n` driven low mid-cycle T+3 → `busy`, `hi`, `lo` = 0 immediately, and the pending result is never written after release.

Source files
------------

// File: rtl/mdu_e.sv
// E-stage multiply/divide unit: mult/multu/div/divu/mthi/mtlo against HI/LO with fixed-latency busy.
// Divider is built only when MDU_DIV_EN is defined; otherwise op 2/3 behave as reserved no-ops.
module mdu_e #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_hi, r_lo, r_p_hi, r_p_lo;

    logic        w_is_mul, w_is_div, w_launch, w_idle, w_done;
    logic [31:0] w_res_hi, w_res_lo;

    logic signed [63:0] w_ma, w_mb, w_prod;

    assign w_is_mul = (op == 3'd0) | (op == 3'd1);
`ifdef MDU_DIV_EN
    assign w_is_div = (op == 3'd2) | (op == 3'd3);
`else
    assign w_is_div = 1'b0;
`endif
    assign w_idle   = (r_state == S_IDLE);
    assign w_launch = start & (w_is_mul | w_is_div);
    assign w_done   = (r_state == S_RUN) & (r_cnt == 5'd1);

    // Low 64 bits of the product are identical for signed and unsigned once operands are extended.
    assign w_ma   = {{32{~op[0] & a[31]}}, a};
    assign w_mb   = {{32{~op[0] & b[31]}}, b};
    assign w_prod = w_ma * w_mb;

`ifdef MDU_DIV_EN
    function automatic logic [31:0] f_neg(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [31:0] f_abs(input logic [31:0] v, input logic sgn);
        return (sgn & v[31]) ? f_neg(v) : v;
    endfunction

    logic        w_sgn, w_bz;
    logic [31:0] w_ua, w_ub, w_ub_safe, w_uq, w_ur, w_q, w_r;

    assign w_sgn     = ~op[0];
    assign w_bz      = (b == 32'd0);
    assign w_ua      = f_abs(a, w_sgn);
    assign w_ub      = f_abs(b, w_sgn);
    assign w_ub_safe = w_bz ? 32'd1 : w_ub;
    assign w_uq      = w_ua / w_ub_safe;
    assign w_ur      = w_ua % w_ub_safe;
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    assign w_q       = (w_sgn & (a[31] ^ b[31])) ? f_neg(w_uq) : w_uq;
    assign w_r       = (w_sgn & a[31]) ? f_neg(w_ur) : w_ur;

    always_comb begin
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        if (w_is_div) begin
            w_res_hi = w_bz ? r_hi : w_r;
            w_res_lo = w_bz ? r_lo : w_q;
        end
    end
`else
    always_comb begin
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = w_is_mul ? 5'(MULT_CYCLES) : 5'(DIV_CYCLES);
                end
            end
            S_RUN: begin
                w_cnt_nxt = r_cnt - 5'd1;
                if (r_cnt == 5'd1) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_hi <= 32'd0;
            r_p_lo <= 32'd0;
        end else if (w_idle & w_launch) begin
            r_p_hi <= w_res_hi;
            r_p_lo <= w_res_lo;
        end
    end

    // Starts arriving during RUN (including mthi/mtlo) are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_done) begin
            r_hi <= r_p_hi;
            r_lo <= r_p_lo;
        end else if (w_idle & start) begin
            if (op == 3'd4) r_hi <= a;
            if (op == 3'd5) r_lo <= a;
        end
    end

    assign busy  = (r_state == S_RUN);
    assign stall = md_use & (busy | w_launch);
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule
